// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs big-endian 32-bit words into 512-bit blocks with FIPS 180-4 padding.
// blockOut layout: [513]=firstBlock, [512]=lastBlock, [511-32*i -: 32]=word i (word 0 in the top bits).
module sha256_padder #(
  parameter int unsigned LEN_BITS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         validIn,
  output logic         readyOut,
  input  logic [31:0]  wordIn,
  input  logic         lastIn,
  input  logic [2:0]   bytesIn,
  output logic         validOut,
  input  logic         readyIn,
  output logic [513:0] blockOut
);

  typedef enum logic [1:0] {Collect, Send, Extra} stateT;

  stateT               state;
  logic [31:0]         buffer [16];
  logic [3:0]          w;
  logic [LEN_BITS-1:0] bitCnt;
  logic                firstPending;
  logic                needExtra;
  logic                padAt64;
  logic                firstFlag;
  logic                lastFlag;

  logic [2:0]          bytesEff;
  logic [2:0]          effBytes;
  logic [31:0]         maskedWord;
  logic [LEN_BITS-1:0] cntNext;
  logic [6:0]          padPos;
  logic [31:0]         lastBuf [16];
  logic [63:0]         lenNext;
  logic [63:0]         lenNow;

  assign readyOut = rst && (state == Collect);

  always_comb begin
    bytesEff = (bytesIn > 3'd4) ? 3'd4 : bytesIn;
    effBytes = lastIn ? bytesEff : 3'd4;
    for (int unsigned b = 0; b < 4; b++)
      maskedWord[31-8*b -: 8] = (3'(b) < effBytes) ? wordIn[31-8*b -: 8] : 8'h00;
    cntNext = bitCnt + LEN_BITS'({effBytes, 3'b000});
    padPos  = 7'({w, 2'b00}) + 7'(bytesEff);
    lenNext = 64'(cntNext);
    lenNow  = 64'(bitCnt);
    // Final-word image of the whole block: stale words past w are cleared, pad byte inserted at p.
    for (int unsigned i = 0; i < 16; i++) begin
      lastBuf[i] = (4'(i) < w) ? buffer[i] : '0;
      if (4'(i) == w) lastBuf[i] = maskedWord;
      for (int unsigned b = 0; b < 4; b++)
        if (padPos < 7'd64 && padPos[5:2] == 4'(i) && padPos[1:0] == 2'(b))
          lastBuf[i][31-8*b -: 8] = 8'h80;
    end
    if (padPos <= 7'd55) begin
      lastBuf[14] = lenNext[63:32];
      lastBuf[15] = lenNext[31:0];
    end
  end

  always_comb begin
    blockOut      = '0;
    blockOut[513] = firstFlag;
    blockOut[512] = lastFlag;
    for (int unsigned i = 0; i < 16; i++)
      blockOut[511-32*i -: 32] = buffer[i];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= Collect;
      w            <= '0;
      bitCnt       <= '0;
      firstPending <= 1'b1;
      needExtra    <= 1'b0;
      padAt64      <= 1'b0;
      validOut     <= 1'b0;
      firstFlag    <= 1'b0;
      lastFlag     <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) buffer[i] <= '0;
    end else begin
      case (state)
        Collect: begin
          if (validIn) begin
            bitCnt <= cntNext;
            if (lastIn) begin
              for (int unsigned i = 0; i < 16; i++) buffer[i] <= lastBuf[i];
              w         <= '0;
              state     <= Send;
              validOut  <= 1'b1;
              firstFlag <= firstPending;
              lastFlag  <= (padPos <= 7'd55);
              needExtra <= (padPos >= 7'd56);
              padAt64   <= (padPos == 7'd64);
            end else begin
              buffer[w] <= maskedWord;
              if (w == 4'd15) begin
                w         <= '0;
                state     <= Send;
                validOut  <= 1'b1;
                firstFlag <= firstPending;
                lastFlag  <= 1'b0;
                needExtra <= 1'b0;
              end else begin
                w <= w + 4'd1;
              end
            end
          end
        end
        Send: begin
          if (readyIn) begin
            validOut     <= 1'b0;
            firstPending <= 1'b0;
            if (needExtra) begin
              state <= Extra;
            end else begin
              state <= Collect;
              if (lastFlag) begin
                bitCnt       <= '0;
                firstPending <= 1'b1;
              end
            end
          end
        end
        Extra: begin
          for (int unsigned i = 0; i < 16; i++) buffer[i] <= '0;
          buffer[0]  <= padAt64 ? 32'h8000_0000 : 32'h0;
          buffer[14] <= lenNow[63:32];
          buffer[15] <= lenNow[31:0];
          firstFlag  <= 1'b0;
          lastFlag   <= 1'b1;
          needExtra  <= 1'b0;
          validOut   <= 1'b1;
          state      <= Send;
        end
        default: state <= Collect;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Randomized bench for sha256_padder against a byte-queue model of FIPS 180-4 padding.
module tb_sha256_padder;

  logic         clk = 1'b0;
  logic         rst;
  logic         validIn;
  logic         readyOut;
  logic [31:0]  wordIn;
  logic         lastIn;
  logic [2:0]   bytesIn;
  logic         validOut;
  logic         readyIn;
  logic [513:0] blockOut;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [513:0] expQ[$];

  sha256_padder #(.LEN_BITS(64)) dut (
    .clk(clk), .rst(rst), .validIn(validIn), .readyOut(readyOut),
    .wordIn(wordIn), .lastIn(lastIn), .bytesIn(bytesIn),
    .validOut(validOut), .readyIn(readyIn), .blockOut(blockOut)
  );

  always #5 clk = ~clk;

  // Reference: append 0x80, zero to 56 mod 64, 64-bit big-endian bit length, cut into 64-byte blocks.
  task automatic buildExpected(input logic [7:0] msg[$]);
    logic [7:0]  pad[$];
    logic [63:0] bitLen;
    logic [511:0] data;
    int unsigned nb;
    expQ.delete();
    pad = msg;
    pad.push_back(8'h80);
    while (pad.size() % 64 != 56) pad.push_back(8'h00);
    bitLen = 64'(msg.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) pad.push_back(bitLen[8*k +: 8]);
    nb = pad.size() / 64;
    for (int unsigned k = 0; k < nb; k++) begin
      for (int unsigned j = 0; j < 64; j++) data[511-8*j -: 8] = pad[64*k+j];
      expQ.push_back({(k == 0), (k == nb - 1), data});
    end
  endtask

  task automatic runMessage(input logic [7:0] msg[$], input int unsigned readyPct,
                            input int unsigned validPct, input string name);
    logic [31:0] words[$];
    logic [2:0]  bytesQ[$];
    logic [31:0] wv;
    int unsigned len, nw, wi, bi, cycles, rem;
    logic [2:0]  bq;
    buildExpected(msg);
    len = msg.size();
    nw  = (len == 0) ? 1 : (len + 3) / 4;
    for (int unsigned k = 0; k < nw; k++) begin
      wv = $urandom;
      for (int unsigned b = 0; b < 4; b++)
        if (4*k + b < len) wv[31-8*b -: 8] = msg[4*k+b];
      rem = len - 4*k;
      bq = (rem >= 4) ? 3'(4 + $urandom_range(0, 3)) : 3'(rem);
      if (k != nw - 1) bq = 3'($urandom_range(0, 7));
      words.push_back(wv);
      bytesQ.push_back(bq);
    end
    if (len > 0 && len % 4 == 0 && $urandom_range(0, 3) == 0) begin
      words.push_back($urandom);
      bytesQ.push_back(3'd0);
      nw++;
    end
    wi = 0; bi = 0; cycles = 0;
    while (bi < expQ.size() && cycles < 3000) begin
      @(negedge clk);
      validIn = (wi < nw) && ($urandom_range(0, 99) < validPct);
      wordIn  = (wi < nw) ? words[wi] : $urandom;
      bytesIn = (wi < nw) ? bytesQ[wi] : 3'($urandom_range(0, 7));
      lastIn  = (wi == nw - 1);
      readyIn = ($urandom_range(0, 99) < readyPct);
      if (validIn && readyOut) wi++;
      if (validOut && readyIn) begin
        vectors++;
        if (blockOut !== expQ[bi]) begin
          miscompares++;
          $display("FAIL %s block%0d got=%h exp=%h", name, bi, blockOut, expQ[bi]);
        end
        bi++;
      end
      @(posedge clk);
      cycles++;
    end
    @(negedge clk);
    validIn = 1'b0; readyIn = 1'b0; lastIn = 1'b0;
    vectors++;
    if (bi != expQ.size() || wi != nw) begin
      miscompares++;
      $display("FAIL %s completion blocks=%0d/%0d words=%0d/%0d", name, bi, expQ.size(), wi, nw);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; validIn = 1'b0; readyIn = 1'b0; wordIn = '0; lastIn = 1'b0; bytesIn = '0;
    #2;
    vectors++;
    if (validOut !== 1'b0 || blockOut !== '0 || readyOut !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state valid=%b ready=%b block=%h", validOut, readyOut, blockOut);
    end
    @(negedge clk); rst = 1'b1; #1;
    vectors++;
    if (readyOut !== 1'b1 || validOut !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release ready=%b valid=%b", readyOut, validOut);
    end
  endtask

  task automatic test_empty();
    logic [7:0] m[$];
    runMessage(m, 100, 100, "empty");
  endtask

  task automatic test_abc_backpressure();
    logic [7:0]   m[$];
    logic [513:0] held;
    m = '{8'h61, 8'h62, 8'h63};
    buildExpected(m);
    @(negedge clk);
    readyIn = 1'b0; validIn = 1'b1; wordIn = 32'h6162_63FF; lastIn = 1'b1; bytesIn = 3'd3;
    vectors++;
    if (readyOut !== 1'b1) begin
      miscompares++; $display("FAIL abc_accept readyOut=%b exp=1", readyOut);
    end
    @(posedge clk);
    @(negedge clk);
    validIn = 1'b0; lastIn = 1'b0; wordIn = $urandom;
    vectors++;
    if (validOut !== 1'b1 || blockOut !== expQ[0]) begin
      miscompares++;
      $display("FAIL abc_latency valid=%b got=%h exp=%h", validOut, blockOut, expQ[0]);
    end
    held = blockOut;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      vectors++;
      if (validOut !== 1'b1 || blockOut !== expQ[0] || readyOut !== 1'b0) begin
        miscompares++;
        $display("FAIL stall%0d valid=%b ready=%b got=%h exp=%h", i, validOut, readyOut, blockOut, expQ[0]);
      end
    end
    readyIn = 1'b1;
    @(posedge clk); @(negedge clk);
    readyIn = 1'b0;
    vectors++;
    if (validOut !== 1'b0 || readyOut !== 1'b1) begin
      miscompares++;
      $display("FAIL single_transfer valid=%b ready=%b exp valid=0 ready=1", validOut, readyOut);
    end
  endtask

  task automatic test_56();
    logic [7:0] m[$];
    for (int i = 0; i < 56; i++) m.push_back(8'($urandom));
    runMessage(m, 100, 100, "len56");
    runMessage(m, 40, 70, "len56_bp");
  endtask

  task automatic test_64();
    logic [7:0] m[$];
    for (int i = 0; i < 64; i++) m.push_back(8'($urandom));
    runMessage(m, 100, 100, "len64");
    runMessage(m, 50, 60, "len64_bp");
  endtask

  task automatic test_back_to_back();
    logic [7:0] m[$];
    m = '{8'h61, 8'h62, 8'h63};
    runMessage(m, 100, 100, "abc_first");
    runMessage(m, 100, 100, "abc_second");
  endtask

  task automatic test_async_reset();
    logic [7:0] m[$];
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      validIn = 1'b1; wordIn = $urandom; lastIn = 1'b0; bytesIn = 3'd4;
      @(posedge clk);
    end
    @(negedge clk);
    validIn = 1'b0;
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (readyOut !== 1'b0 || validOut !== 1'b0 || blockOut !== '0) begin
      miscompares++;
      $display("FAIL async_reset ready=%b valid=%b block=%h", readyOut, validOut, blockOut);
    end
    @(negedge clk); rst = 1'b1;
    m = '{8'h61, 8'h62, 8'h63};
    runMessage(m, 100, 100, "abc_after_reset");
  endtask

  task automatic test_random();
    logic [7:0] m[$];
    for (int n = 0; n < 25; n++) begin
      m.delete();
      for (int unsigned i = 0; i < $urandom_range(0, 140); i++) m.push_back(8'($urandom));
      runMessage(m, $urandom_range(30, 100), $urandom_range(50, 100), "random");
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_abc_backpressure();
    test_56();
    test_64();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sha256_padder.md
Name: sha256_padder

Overview:
- Message-side front end of the SHA-256 datapath.
- Accepts a message as a stream of big-endian 32-bit words and applies FIPS 180-4 padding: a 0x80 byte, zero fill, and a 64-bit big-endian bit length.
- Emits 512-bit blocks tagged firstBlock/lastBlock over a valid/ready stream, in exactly the HasherBlock form the hasher consumes.
- Sits directly upstream of the hasher block input port.

Parameters:
- LEN_BITS, 64, width of the internal bit-length counter; zero-extended to 64 bits in the length field; wraps modulo 2^LEN_BITS.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- validIn  input  1  input word valid.
- readyOut  output  1  padder can accept an input word.
- wordIn  input  32  message word, first byte in bits [31:24].
- lastIn  input  1  final word of the message.
- bytesIn  input  3  valid bytes in wordIn when lastIn=1 (0..4; 5..7 treated as 4); ignored when lastIn=0 (4 assumed).
- validOut  output  1  blockOut holds a complete block.
- readyIn  input  1  downstream accepts the block.
- blockOut  output  HasherBlock (1+1+16x32)  block words [0..15] plus firstBlock and lastBlock flags.

Behaviour:
- Reset (rst=0, asynchronous):
  - State=Collect, word index w=0, bit counter=0, firstPending=1, needExtra=0.
  - validOut=0; all blockOut words and flags =0.
  - readyOut=1 once rst deasserts.
  - A partial message in progress is discarded; the stream restarts at the next word.
- Handshakes:
  - Input transfer = validIn & readyOut.
  - Output transfer = validOut & readyIn.
  - readyOut is decoded combinationally from the state register and is 1 only in Collect.
- State Collect:
  - Each input transfer writes the masked word to buffer[w], adds 32 (or 8*bytesIn on the last word) to the bit counter, and increments w.
  - Bytes beyond bytesIn are forced to 0.
  - Word with w==15 and lastIn=0 -> Send, with lastBlock=0.
  - Word with lastIn=1: let p = 4*w + bytesIn (byte offset of the pad byte).
    - p<64: byte p = 0x80; bytes p+1..63 = 0.
    - p<=55: words 14/15 = 64-bit length including this word; lastBlock=1; needExtra=0.
    - p>=56: lastBlock=0; needExtra=1.
    - Either case -> Send.
- State Send:
  - validOut=1; blockOut and flags held stable until readyIn.
  - On output transfer: firstPending=0.
    - If needExtra -> Extra.
    - Else if lastBlock -> Collect with w=0, counter=0, firstPending=1.
    - Else -> Collect with w=0.
- State Extra (one cycle):
  - Buffer loaded with zeros and length in words 14/15.
  - Word 0 = 0x80000000 when p==64; otherwise word 0 = 0.
  - lastBlock=1, firstBlock=0, needExtra=0 -> Send.
- firstBlock on blockOut equals firstPending at the time the block enters Send.
- Latency: final input word accepted at cycle N -> validOut=1 at N+1. Extra block: validOut at the 2nd cycle after the first block's transfer.
- Throughput: at most 1 word/cycle in; no input accepted while Send/Extra.
- lastIn with w==0 and bytesIn=0 is the empty message: a single block, word0=0x80000000, length 0.
- The bit counter wraps silently on overflow.

Test Plan:
- Empty message: single word, lastIn=1, bytesIn=0 -> one block: word0=0x80000000, words1..15=0, firstBlock=1, lastBlock=1.
- "abc": wordIn=0x616263FF, lastIn=1, bytesIn=3 -> word0=0x61626380, word15=0x00000018, first=last=1, validOut one cycle after accept; garbage byte masked.
- 56-byte message (14 full words, last bytesIn=4):
  - Block 1: word14=0x80000000, word15=0, first=1, last=0.
  - Block 2: words0..14=0, word15=0x000001C0, first=0, last=1.
- 64-byte message (16 words, last bytesIn=4):
  - Block 1: data only, first=1, last=0.
  - Block 2: word0=0x80000000, word15=0x00000200, last=1.
- Backpressure: hold readyIn=0 for 10 cycles during Send -> validOut, blockOut, and flags stable; readyOut=0 throughout; a single transfer when readyIn rises. Then two back-to-back "abc" messages -> both blocks have firstBlock=1.
- Assert rst=0 asynchronously mid-message (w=7) -> validOut=0 and readyOut low immediately. After release, an "abc" message yields the exact block from the "abc" scenario with firstBlock=1.
